stack_op_issuer: RTL and testbench

Initiator for the EVM operand stack: accepts one decoded stack-manipulation opcode at a time (POP, PUSH0..PUSH32, DUP1..DUP16, SWAP1..SWAP16) and turns it into a single-cycle push/pop/data request on the stack's write port. It reads the top 17 stack words and the stack height, checks underflow and overflow before issuing, and raises a sticky fault instead of corrupting the stack. It sits between the opcode decoder and the stack and is the only driver of the stack's push_num, pop_num and data_in.

---
 rtl/stack_pkg.sv | 44 ++++
 rtl/stack_op_decode.sv | 58 +++++
 rtl/stack_op_issuer.sv | 179 +++++++++++++++++
 tb/tb_stack_op_issuer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the EVM operand-stack issuer and the decoder's gas
// stage: stack geometry, opcode anchor constants, fault codes, the issuer
// state encoding and the opcode class produced by stack_op_decode.
// Optional feature macro (consumed by the users of this package):
//   STACK_ISSUE_SWAP_EN - enables SWAP1..SWAP16 and data lanes 1..16.
// -----------------------------------------------------------------------------
package stack_pkg;

  localparam int STACK_DEPTH = 1024;
  localparam int STACK_LANES = 17;
  localparam int WORD_W      = 256;
  localparam int HEIGHT_W    = $clog2(STACK_DEPTH);

  localparam logic [7:0] OP_POP   = 8'h50;
  localparam logic [7:0] OP_PUSH0 = 8'h5F;
  localparam logic [7:0] OP_PUSH1 = 8'h60;
  localparam logic [7:0] OP_DUP1  = 8'h80;
  localparam logic [7:0] OP_SWAP1 = 8'h90;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    UNDERFLOW = 2'd1,
    OVERFLOW  = 2'd2,
    INVALID   = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_POP     = 3'd0,
    CLS_PUSH0   = 3'd1,
    CLS_PUSH    = 3'd2,
    CLS_DUP     = 3'd3,
    CLS_SWAP    = 3'd4,
    CLS_INVALID = 3'd5
  } op_class_e;

endpackage

// File: rtl/stack_op_decode.sv
// -----------------------------------------------------------------------------
// stack_op_decode
// Purely combinational classification of a stack-manipulation opcode.
// Ports:
//   op_code_i  opcode byte
//   cls_o      opcode class (CLS_INVALID for anything unsupported)
//   pop_o      words popped (p)
//   push_o     words pushed (q)
//   req_o      minimum stack height required (r)
//   lane_o     stack_rd index feeding data lane 0 (DUPn: n-1, SWAPn: n)
// Macro STACK_ISSUE_SWAP_EN: when undefined, 0x90..0x9F decode as invalid.
// -----------------------------------------------------------------------------
module stack_op_decode
  import stack_pkg::*;
(
  input  logic [7:0] op_code_i,
  output op_class_e  cls_o,
  output logic [4:0] pop_o,
  output logic [4:0] push_o,
  output logic [4:0] req_o,
  output logic [4:0] lane_o
);

  always_comb begin
    cls_o  = CLS_INVALID;
    pop_o  = '0;
    push_o = '0;
    req_o  = '0;
    lane_o = '0;
    if (op_code_i == OP_POP) begin
      cls_o = CLS_POP;
      pop_o = 5'd1;
      req_o = 5'd1;
    end else if (op_code_i == OP_PUSH0) begin
      cls_o  = CLS_PUSH0;
      push_o = 5'd1;
    end else if (op_code_i >= OP_PUSH1 && op_code_i < OP_DUP1) begin
      cls_o  = CLS_PUSH;
      push_o = 5'd1;
    end else if (op_code_i[7:4] == OP_DUP1[7:4]) begin
      // DUPn copies stack_rd[n-1]; low nibble is already n-1
      cls_o  = CLS_DUP;
      push_o = 5'd1;
      lane_o = {1'b0, op_code_i[3:0]};
      req_o  = {1'b0, op_code_i[3:0]} + 5'd1;
`ifdef STACK_ISSUE_SWAP_EN
    end else if (op_code_i[7:4] == OP_SWAP1[7:4]) begin
      // SWAPn touches n+1 words: pop them all and push them back reordered
      cls_o  = CLS_SWAP;
      lane_o = {1'b0, op_code_i[3:0]} + 5'd1;
      req_o  = {1'b0, op_code_i[3:0]} + 5'd2;
      pop_o  = req_o;
      push_o = req_o;
`endif
    end
  end

endmodule

// File: rtl/stack_op_issuer.sv
// -----------------------------------------------------------------------------
// stack_op_issuer
// Turns one decoded stack opcode at a time into a single-cycle push/pop/data
// request for the EVM operand stack, after checking underflow, overflow and
// opcode validity. Errors raise a sticky fault instead of issuing.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   op_valid/op_ready   opcode handshake (op_ready = IDLE && !fault)
//   op_code, op_imm     opcode byte and right-aligned PUSHn immediate
//   stack_rd            top 17 stack words, index 0 = top of stack
//   stack_height        current stack height
//   push_num, pop_num   request counts, nonzero only in the ISSUE cycle
//   data_in             write words, index 0 becomes the new top
//   done                one-cycle pulse in the ISSUE cycle
//   fault, fault_code   sticky error flag and its cause
//   fault_clr           clears fault and fault_code
// Macro STACK_ISSUE_SWAP_EN: enables SWAPn and registers for lanes 1..16;
// when undefined those lanes are constant zero.
// -----------------------------------------------------------------------------
module stack_op_issuer
  import stack_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 op_valid,
  output logic                                 op_ready,
  input  logic [7:0]                           op_code,
  input  logic [WORD_W-1:0]                    op_imm,
  input  logic [STACK_LANES-1:0][WORD_W-1:0]   stack_rd,
  input  logic [HEIGHT_W-1:0]                  stack_height,
  output logic [4:0]                           push_num,
  output logic [4:0]                           pop_num,
  output logic [STACK_LANES-1:0][WORD_W-1:0]   data_in,
  output logic                                 done,
  output logic                                 fault,
  output logic [1:0]                           fault_code,
  input  logic                                 fault_clr
);

  state_e            state_q, state_d;
  logic [7:0]        op_code_q, op_code_d;
  logic [WORD_W-1:0] op_imm_q, op_imm_d;
  logic [4:0]        push_q, push_d, pop_q, pop_d;
  logic [WORD_W-1:0] lane0_q, lane0_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  fault_e            code_q, code_d;

  op_class_e  cls;
  logic [4:0] dec_p, dec_q, dec_r, dec_n;

  stack_op_decode u_decode (
    .op_code_i (op_code_q),
    .cls_o     (cls),
    .pop_o     (dec_p),
    .push_o    (dec_q),
    .req_o     (dec_r),
    .lane_o    (dec_n)
  );

  // Height checks in 11 bits so height + q cannot wrap before the compare.
  // Underflow is tested first, so height + q - p never goes negative here.
  logic [10:0] height_ext, after_ext;
  fault_e      chk_code;

  assign height_ext = {1'b0, stack_height};
  assign after_ext  = height_ext + {6'd0, dec_q} - {6'd0, dec_p};

  always_comb begin
    chk_code = NONE;
    if (cls == CLS_INVALID)                    chk_code = INVALID;
    else if (height_ext < {6'd0, dec_r})       chk_code = UNDERFLOW;
    else if (after_ext > 11'(STACK_DEPTH - 1)) chk_code = OVERFLOW;
  end

  assign op_ready = (state_q == IDLE) && !fault_q;

  always_comb begin
    state_d   = state_q;
    op_code_d = op_code_q;
    op_imm_d  = op_imm_q;
    push_d    = '0;
    pop_d     = '0;
    lane0_d   = '0;
    done_d    = 1'b0;
    fault_d   = fault_q;
    code_d    = code_q;
    if (fault_clr) begin
      fault_d = 1'b0;
      code_d  = NONE;
    end
    case (state_q)
      IDLE: begin
        if (op_valid && op_ready) begin
          op_code_d = op_code;
          op_imm_d  = op_imm;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        // A fault raised here overrides a simultaneous fault_clr.
        if (chk_code != NONE) begin
          fault_d = 1'b1;
          code_d  = chk_code;
          state_d = IDLE;
        end else begin
          push_d  = dec_q;
          pop_d   = dec_p;
          done_d  = 1'b1;
          state_d = ISSUE;
          case (cls)
            CLS_PUSH:          lane0_d = op_imm_q;
            CLS_DUP, CLS_SWAP: lane0_d = stack_rd[dec_n];
            default:           lane0_d = '0;
          endcase
        end
      end
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      push_q  <= '0;
      pop_q   <= '0;
      lane0_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= NONE;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      lane0_q <= lane0_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  // Latched opcode is only consumed in CHECK, after a load, so it needs no reset.
  always_ff @(posedge clk) begin
    op_code_q <= op_code_d;
    op_imm_q  <= op_imm_d;
  end

`ifdef STACK_ISSUE_SWAP_EN
  logic [STACK_LANES-1:1][WORD_W-1:0] hi_q, hi_d;

  // SWAPn: lane n receives the old top, lanes below n pass through unchanged.
  always_comb begin
    hi_d = '0;
    if (state_q == CHECK && chk_code == NONE && cls == CLS_SWAP) begin
      for (int i = 1; i < STACK_LANES; i++) begin
        if (5'(i) < dec_n)       hi_d[i] = stack_rd[i];
        else if (5'(i) == dec_n) hi_d[i] = stack_rd[0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hi_q <= '0;
    else     hi_q <= hi_d;
  end

  assign data_in = {hi_q, lane0_q};
`else
  assign data_in = {{((STACK_LANES - 1) * WORD_W){1'b0}}, lane0_q};
`endif

  assign push_num   = push_q;
  assign pop_num    = pop_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_stack_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_stack_op_issuer
// Directed, table-driven bench for stack_op_issuer plus hand-written sequences
// for reset, sticky fault / fault_clr priority and reset during CHECK.
// stack_rd is held at rd[i] = i+1 throughout.
// Macro STACK_ISSUE_SWAP_EN selects the SWAP expectations.
// -----------------------------------------------------------------------------
module tb_stack_op_issuer;
  import stack_pkg::*;

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               op_valid;
  logic                               op_ready;
  logic [7:0]                         op_code;
  logic [WORD_W-1:0]                  op_imm;
  logic [STACK_LANES-1:0][WORD_W-1:0] stack_rd;
  logic [HEIGHT_W-1:0]                stack_height;
  logic [4:0]                         push_num;
  logic [4:0]                         pop_num;
  logic [STACK_LANES-1:0][WORD_W-1:0] data_in;
  logic                               done;
  logic                               fault;
  logic [1:0]                         fault_code;
  logic                               fault_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stack_op_issuer dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_imm       (op_imm),
    .stack_rd     (stack_rd),
    .stack_height (stack_height),
    .push_num     (push_num),
    .pop_num      (pop_num),
    .data_in      (data_in),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .fault_clr    (fault_clr)
  );

  typedef struct {
    logic [7:0]        op;
    logic [WORD_W-1:0] imm;
    logic [9:0]        h;
    logic [1:0]        code;
    logic [4:0]        push;
    logic [4:0]        pop;
    logic [WORD_W-1:0] lane0;
    int                hi_idx;
    logic [WORD_W-1:0] hi_val;
    logic              mid;     // lanes 1..hi_idx-1 pass stack_rd through
  } vec_t;

  vec_t vt[16];
  int   nv = 0;

  task automatic add(input logic [7:0] op, input logic [WORD_W-1:0] imm,
                     input logic [9:0] h, input logic [1:0] code,
                     input logic [4:0] push, input logic [4:0] pop,
                     input logic [WORD_W-1:0] lane0, input int hi_idx,
                     input logic [WORD_W-1:0] hi_val, input logic mid);
    vt[nv].op     = op;
    vt[nv].imm    = imm;
    vt[nv].h      = h;
    vt[nv].code   = code;
    vt[nv].push   = push;
    vt[nv].pop    = pop;
    vt[nv].lane0  = lane0;
    vt[nv].hi_idx = hi_idx;
    vt[nv].hi_val = hi_val;
    vt[nv].mid    = mid;
    nv++;
  endtask

  task automatic chk(input string name, input logic [WORD_W-1:0] act,
                     input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int waited = 0;
    while (op_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk(name, 256'(op_ready), 256'(1'b1));
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_push"}, 256'(push_num), 256'(0));
    chk({name, "_pop"},  256'(pop_num),  256'(0));
    chk({name, "_done"}, 256'(done),     256'(0));
    chk({name, "_data"}, 256'(|data_in), 256'(0));
  endtask

  task automatic run_vec(input int k);
    vec_t              v;
    logic [WORD_W-1:0] exp_lane;
    v = vt[k];
    @(negedge clk);
    wait_ready($sformatf("v%0d_ready_before", k));
    op_valid     = 1'b1;
    op_code      = v.op;
    op_imm       = v.imm;
    stack_height = v.h;
    @(negedge clk);
    // now in CHECK; scramble the handshake inputs to prove they were latched
    op_valid = 1'b0;
    op_code  = 8'h00;
    op_imm   = ~v.imm;
    @(negedge clk);
    chk($sformatf("v%0d_push", k),  256'(push_num),   256'(v.push));
    chk($sformatf("v%0d_pop", k),   256'(pop_num),    256'(v.pop));
    chk($sformatf("v%0d_done", k),  256'(done),       256'(v.code == 2'd0));
    chk($sformatf("v%0d_fault", k), 256'(fault),      256'(v.code != 2'd0));
    chk($sformatf("v%0d_code", k),  256'(fault_code), 256'(v.code));
    chk($sformatf("v%0d_ready", k), 256'(op_ready),   256'(1'b0));
    chk($sformatf("v%0d_lane0", k), data_in[0],       v.lane0);
    for (int j = 1; j < STACK_LANES; j++) begin
      if (j == v.hi_idx)            exp_lane = v.hi_val;
      else if (v.mid && j < v.hi_idx) exp_lane = 256'(j + 1);
      else                          exp_lane = '0;
      chk($sformatf("v%0d_lane%0d", k, j), data_in[j], exp_lane);
    end
    @(negedge clk);
    chk_idle_outputs($sformatf("v%0d_after", k));
    chk($sformatf("v%0d_ready_after", k), 256'(op_ready), 256'(v.code == 2'd0));
    if (v.code != 2'd0) begin
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk($sformatf("v%0d_clr_fault", k), 256'(fault),      256'(0));
      chk($sformatf("v%0d_clr_code", k),  256'(fault_code), 256'(0));
      chk($sformatf("v%0d_clr_ready", k), 256'(op_ready),   256'(1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [WORD_W-1:0] big;
    big = {4{64'hDEAD_BEEF_0123_4567}};

    rst          = 1'b1;
    op_valid     = 1'b0;
    op_code      = 8'h00;
    op_imm       = '0;
    stack_height = '0;
    fault_clr    = 1'b0;
    for (int i = 0; i < STACK_LANES; i++) stack_rd[i] = 256'(i + 1);

    //   op     imm        h     code push pop lane0       hi  hi_val mid
    add(8'h60, 256'hAB,   10'd0,    2'd0, 5'd1, 5'd0, 256'hAB, 1, '0, 1'b0); // PUSH1
    add(8'h82, '0,        10'd3,    2'd0, 5'd1, 5'd0, 256'd3,  1, '0, 1'b0); // DUP3
    add(8'h50, '0,        10'd5,    2'd0, 5'd0, 5'd1, '0,      1, '0, 1'b0); // POP
    add(8'h7F, big,       10'd1022, 2'd0, 5'd1, 5'd0, big,     1, '0, 1'b0); // PUSH32 to full
    add(8'h8F, '0,        10'd16,   2'd0, 5'd1, 5'd0, 256'd16, 1, '0, 1'b0); // DUP16
    add(8'h8F, '0,        10'd15,   2'd1, 5'd0, 5'd0, '0,      1, '0, 1'b0); // DUP16 underflow
    add(8'h50, '0,        10'd0,    2'd1, 5'd0, 5'd0, '0,      1, '0, 1'b0); // POP underflow
    add(8'h5F, '0,        10'd1023, 2'd2, 5'd0, 5'd0, '0,      1, '0, 1'b0); // PUSH0 overflow
    add(8'h80, '0,        10'd1023, 2'd2, 5'd0, 5'd0, '0,      1, '0, 1'b0); // DUP1 overflow
    add(8'h5F, 256'h55,   10'd1022, 2'd0, 5'd1, 5'd0, '0,      1, '0, 1'b0); // PUSH0 ignores imm
    add(8'h01, '0,        10'd5,    2'd3, 5'd0, 5'd0, '0,      1, '0, 1'b0); // invalid
    add(8'h5E, '0,        10'd5,    2'd3, 5'd0, 5'd0, '0,      1, '0, 1'b0); // invalid
    add(8'hA0, '0,        10'd5,    2'd3, 5'd0, 5'd0, '0,      1, '0, 1'b0); // invalid
`ifdef STACK_ISSUE_SWAP_EN
    add(8'h93, '0,        10'd5,    2'd0, 5'd5,  5'd5,  256'd5,  4,  256'd1, 1'b1); // SWAP4
    add(8'h9F, '0,        10'd17,   2'd0, 5'd17, 5'd17, 256'd17, 16, 256'd1, 1'b1); // SWAP16
    add(8'h90, '0,        10'd2,    2'd0, 5'd2,  5'd2,  256'd2,  1,  256'd1, 1'b1); // SWAP1
`else
    add(8'h93, '0,        10'd5,    2'd3, 5'd0, 5'd0, '0,      1, '0, 1'b0); // SWAP4 disabled
    add(8'h9F, '0,        10'd17,   2'd3, 5'd0, 5'd0, '0,      1, '0, 1'b0); // SWAP16 disabled
    add(8'h90, '0,        10'd2,    2'd3, 5'd0, 5'd0, '0,      1, '0, 1'b0); // SWAP1 disabled
`endif

    // Reset state, observed while rst is held
    repeat (2) @(negedge clk);
    chk_idle_outputs("rst_hold");
    chk("rst_ready", 256'(op_ready),   256'(1'b1));
    chk("rst_fault", 256'(fault),      256'(0));
    chk("rst_code",  256'(fault_code), 256'(0));
    rst = 1'b0;

    for (int k = 0; k < nv; k++) run_vec(k);

    // fault_clr coinciding with a new fault: the new fault wins, then sticks
    @(negedge clk);
    wait_ready("clr_race_ready");
    op_valid     = 1'b1;
    op_code      = OP_POP;
    stack_height = 10'd0;
    @(negedge clk);
    op_valid  = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_race_fault", 256'(fault),      256'(1'b1));
    chk("clr_race_code",  256'(fault_code), 256'(2'd1));
    op_valid     = 1'b1;
    op_code      = OP_PUSH1;
    stack_height = 10'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("sticky%0d_fault", c), 256'(fault),    256'(1'b1));
      chk($sformatf("sticky%0d_ready", c), 256'(op_ready), 256'(1'b0));
      chk_idle_outputs($sformatf("sticky%0d", c));
    end
    op_valid  = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("sticky_clr_ready", 256'(op_ready), 256'(1'b1));
    chk("sticky_clr_code",  256'(fault_code), 256'(0));

    // Reset asserted during CHECK of a POP aborts it without a pop
    @(negedge clk);
    wait_ready("rst_mid_ready");
    op_valid     = 1'b1;
    op_code      = OP_POP;
    stack_height = 10'd5;
    @(negedge clk);
    op_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk_idle_outputs("rst_mid_async");
    chk("rst_mid_async_ready", 256'(op_ready), 256'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle_outputs($sformatf("rst_mid%0d", c));
      chk($sformatf("rst_mid%0d_fault", c), 256'(fault),    256'(0));
      chk($sformatf("rst_mid%0d_ready", c), 256'(op_ready), 256'(1'b1));
    end

    // Normal operation resumes after the aborted opcode
    for (int k = 0; k < 2; k++) run_vec(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
